clock_divider_bank: RTL and testbench



---
 rtl/clock_divider_bank.sv | 101 ++++++++++
 tb/tb_clock_divider_bank.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: divides MHz50 into 2 MHz / 31.25 kHz / 250 Hz square waves with wrap ticks, and debounces the speed-select switches
//
// Ports:
//   MHz50       board clock, the only clock
//   reset       asynchronous active-high reset
//   sw_raw      raw switch levels (bit1 = switch 7, bit0 = switch 6), asynchronous
//   MHz2/KHz31/Hz250           divided square waves, high for floor(N/2) cycles per period
//   tick_2m/tick_31k/tick_250  one-cycle pulse in the last low cycle of each period
//   sw_out      debounced switch value
//   sw_changed  one-cycle pulse when sw_out updates

// clock_divider_ch: one free-running divider channel; wrap_o is the combinational end-of-period condition
module clock_divider_ch #(
  parameter int N = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic out_o,
  output logic wrap_o
);
  localparam int W = (N > 2) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] HALF = W'(N / 2);
  logic [W-1:0] cnt_q, cnt_d;
  logic out_q;
  always_comb begin
    wrap_o = (cnt_q == LAST);
    cnt_d = wrap_o ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= (cnt_q < HALF);
    end
  end
  assign out_o = out_q;
endmodule

module clock_divider_bank #(
  parameter int         DIV_2M    = 25,
  parameter int         DIV_31K   = 1600,
  parameter int         DIV_250   = 200000,
  parameter int         DEB_COUNT = 4,
  parameter logic [1:0] SW_RESET  = 2'b11
) (
  input  logic       MHz50,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  output logic       MHz2,
  output logic       KHz31,
  output logic       Hz250,
  output logic       tick_2m,
  output logic       tick_31k,
  output logic       tick_250,
  output logic [1:0] sw_out,
  output logic       sw_changed
);
  localparam int MW = $clog2(DEB_COUNT + 1);
  localparam logic [MW-1:0] DEB = MW'(DEB_COUNT);
  logic w2m, w31k, w250;
  logic [2:0] tick_q;
  logic [1:0] sync1_q, sync2_q, cand_q, cand_d, sw_q, sw_d;
  logic [MW-1:0] match_q, match_d;
  logic chg_q, chg_d, differ;
  clock_divider_ch #(.N(DIV_2M))  u_2m  (.clk_i(MHz50), .rst_i(reset), .out_o(MHz2),  .wrap_o(w2m));
  clock_divider_ch #(.N(DIV_31K)) u_31k (.clk_i(MHz50), .rst_i(reset), .out_o(KHz31), .wrap_o(w31k));
  clock_divider_ch #(.N(DIV_250)) u_250 (.clk_i(MHz50), .rst_i(reset), .out_o(Hz250), .wrap_o(w250));
  // switches are sampled only on the Hz250 wrap; a differing sample restarts the count on the new value
  always_comb begin
    differ  = (sync2_q != cand_q);
    cand_d  = (w250 && differ) ? sync2_q : cand_q;
    match_d = !w250 ? match_q : differ ? MW'(1) : (match_q < DEB) ? match_q + MW'(1) : match_q;
    chg_d   = (match_q == DEB) && (cand_q != sw_q);
    sw_d    = chg_d ? cand_q : sw_q;
  end
  always_ff @(posedge MHz50 or posedge reset) begin
    if (reset) begin
      tick_q  <= '0;
      sync1_q <= SW_RESET;
      sync2_q <= SW_RESET;
      cand_q  <= SW_RESET;
      match_q <= '0;
      sw_q    <= SW_RESET;
      chg_q   <= 1'b0;
    end else begin
      tick_q  <= {w250, w31k, w2m};
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      match_q <= match_d;
      sw_q    <= sw_d;
      chg_q   <= chg_d;
    end
  end
  assign {tick_250, tick_31k, tick_2m} = tick_q;
  assign sw_out     = sw_q;
  assign sw_changed = chg_q;
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed checks of divider waveforms, ticks, switch debounce and mid-operation reset
module tb_clock_divider_bank;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] sw_raw;
  logic mhz2, khz31, hz250, t2m, t31k, t250, chg;
  logic [1:0] swo;
  logic b_mhz2, b_khz31, b_hz250, b_t2m, b_t31k, b_t250, b_chg;
  logic [1:0] b_swo;
  int k = 0;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clock_divider_bank #(.DIV_2M(25), .DIV_31K(4), .DIV_250(10), .DEB_COUNT(4)) u0 (
    .MHz50(clk), .reset(reset), .sw_raw(sw_raw),
    .MHz2(mhz2), .KHz31(khz31), .Hz250(hz250),
    .tick_2m(t2m), .tick_31k(t31k), .tick_250(t250),
    .sw_out(swo), .sw_changed(chg)
  );

  clock_divider_bank #(.DIV_2M(3), .DIV_31K(2), .DIV_250(5), .DEB_COUNT(4)) u1 (
    .MHz50(clk), .reset(reset), .sw_raw(sw_raw),
    .MHz2(b_mhz2), .KHz31(b_khz31), .Hz250(b_hz250),
    .tick_2m(b_t2m), .tick_31k(b_t31k), .tick_250(b_t250),
    .sw_out(b_swo), .sw_changed(b_chg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // edge k after release sees counter value (k-1) mod n
  function automatic logic sq(input int kk, input int n);
    return ((kk - 1) % n) < (n / 2);
  endfunction

  function automatic logic tk(input int kk, input int n);
    return ((kk - 1) % n) == (n - 1);
  endfunction

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic restart();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    k = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mhz2"}, mhz2, 1'b0);
    chk({tag, "_khz31"}, khz31, 1'b0);
    chk({tag, "_hz250"}, hz250, 1'b0);
    chk({tag, "_ticks"}, {t2m, t31k, t250}, 3'b000);
    chk({tag, "_sw_out"}, swo, 2'b11);
    chk({tag, "_sw_changed"}, chg, 1'b0);
  endtask

  task automatic chk_sw(input int accept_k, input logic [1:0] new_val);
    chk("sw_out", swo, (accept_k > 0 && k >= accept_k) ? new_val : 2'b11);
    chk("sw_changed", chg, (k == accept_k) ? 1'b1 : 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    sw_raw = 2'b11;
    @(negedge clk);
    chk_reset_state("por");
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    // waveforms and ticks, switches idle at the reset value
    for (int i = 0; i < 100; i++) begin
      step();
      chk("mhz2", mhz2, sq(k, 25));
      chk("tick_2m", t2m, tk(k, 25));
      chk("khz31_n4", khz31, sq(k, 4));
      chk("tick_31k_n4", t31k, tk(k, 4));
      chk("hz250_n10", hz250, sq(k, 10));
      chk("tick_250_n10", t250, tk(k, 10));
      chk("b_mhz2_n3", b_mhz2, sq(k, 3));
      chk("b_khz31_n2", b_khz31, sq(k, 2));
      chk("b_tick_31k_n2", b_t31k, 1'b0 == sq(k, 2));
      chk("b_hz250_n5", b_hz250, sq(k, 5));
      chk("b_tick_250_n5", b_t250, tk(k, 5));
      chk_sw(0, 2'b11);
      if (k == 1)  chk("mhz2_first_high", mhz2, 1'b1);
      if (k == 12) chk("mhz2_last_high", mhz2, 1'b1);
      if (k == 13) chk("mhz2_first_low", mhz2, 1'b0);
      if (k == 25) chk("tick_2m_last_low", {t2m, mhz2}, 2'b10);
      if (k == 26) chk("mhz2_rehigh", {t2m, mhz2}, 2'b01);
      if (k == 5)  chk("b_tick_250_p5", b_t250, 1'b1);
      if (k == 3)  chk("b_hz250_low3", b_hz250, 1'b0);
    end
    // held change 11->01: samples at edges 20..50, accepted on edge 51
    restart();
    for (int i = 0; i < 60; i++) begin
      step();
      if (k == 10) sw_raw = 2'b01;
      chk("tick_250", t250, (k % 10) == 0);
      chk_sw(51, 2'b01);
    end
    // bounce back to 11 after one sample: nothing accepted
    sw_raw = 2'b11;
    restart();
    for (int i = 0; i < 80; i++) begin
      step();
      if (k == 10) sw_raw = 2'b01;
      if (k == 25) sw_raw = 2'b11;
      chk_sw(0, 2'b11);
    end
    // reset in the middle of a debounce (match = 3) and a divider period
    restart();
    for (int i = 0; i < 45; i++) begin
      step();
      if (k == 10) sw_raw = 2'b01;
      chk_sw(0, 2'b11);
    end
    chk("pre_reset_khz31", khz31, 1'b1);
    chk("pre_reset_hz250", hz250, 1'b1);
    #2 reset = 1'b1;
    #1 chk_reset_state("mid");
    @(negedge clk);
    chk_reset_state("held");
    reset = 1'b0;
    k = 0;
    // 01 is already present: samples at edges 10..40, accepted on edge 41
    for (int i = 0; i < 50; i++) begin
      step();
      chk("post_mhz2", mhz2, sq(k, 25));
      chk("post_tick_2m", t2m, tk(k, 25));
      chk_sw(41, 2'b01);
    end
    // 11->10->00: only 00 accepted, samples at edges 40..70, accepted on edge 71
    sw_raw = 2'b11;
    restart();
    for (int i = 0; i < 90; i++) begin
      step();
      if (k == 10) sw_raw = 2'b10;
      if (k == 30) sw_raw = 2'b00;
      chk_sw(71, 2'b00);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
